chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Multi-cycle, parametrised add/subtract unit and next generation of the team's combinational flag-producing adder.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, with the carry held in a register between cycles.
- Trades latency for a short carry chain. Adds a start/busy/done handshake, a subtract mode, and registered result flags.
- Sits in the datapath wherever wide arithmetic must not be on the critical path.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; N = WIDTH/CHUNK cycles per operation. CHUNK == WIDTH gives single-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy==0
- sub  input  1  0: a+b+cin; 1: a-b-cin (borrow-in); sampled with start
- cin  input  1  carry-in / borrow-in; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results updated in this cycle
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out of MSB; in sub mode 1 means no borrow
- overflow  output  1  two's-complement overflow
- zero  output  1  sum == 0
- sign  output  1  true sign of the mathematical result

Behaviour:
- Reset (rst high at a clock edge, including mid-operation):
  - busy, done, sum, cout, overflow, zero and sign all go to 0; FSM goes to IDLE.
  - Any in-flight operation is discarded and done is not pulsed.
  - rst has priority over start.
- FSM has two states, IDLE and RUN.
- IDLE + start at edge E0:
  - Latch a.
  - Latch b_eff = sub ? ~b : b.
  - Set carry register = sub ? ~cin : cin.
  - Set chunk index = 0 and go to RUN; busy=1 after E0.
- RUN, edges E1..EN:
  - Edge Ek adds slice k-1 (bits [k*CHUNK-1:(k-1)*CHUNK], LSB slice first) of a and b_eff plus the carry register.
  - Slice sum goes into an internal result register; slice carry-out goes into the carry register.
  - No combinational path spans more than CHUNK+1 bits.
- Completion at EN:
  - Go to IDLE, busy=0, done=1 for exactly one cycle.
  - Update all outputs together:
    - sum = internal result
    - cout = final carry
    - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB])
    - zero = (sum == 0), independent of overflow
    - sign = sum[MSB] ^ overflow
- Outputs sum/cout/overflow/zero/sign change only at completion or reset; they hold stale values while busy.
- start while busy==1, including the cycle of EN, is ignored: no queuing, no effect on the operation in flight.
- start in the cycle done==1 (busy==0) is accepted, so back-to-back operations take N+1 cycles each.
- Operand inputs may change freely after E0; only latched copies are used.
- Latency: done is observed N clock edges after the accepting edge.
- Arithmetic is modulo 2^WIDTH; cout is the bit WIDTH of the (WIDTH+1)-bit sum.

Test Plan:
- WIDTH=16, CHUNK=4, add: a=0x7FFF, b=0x0001, cin=0 -> done 4 edges after start; sum=0x8000, overflow=1, sign=0, zero=0, cout=0; busy high for exactly 4 cycles.
- Add: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, overflow=0, sign=0.
- Subtract: sub=1, a=0x0005, b=0x0005, cin=0 -> sum=0x0000, cout=1, zero=1, overflow=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1, sign=1, cout=1.
- Subtract with borrow: sub=1, a=0x0003, b=0x0005, cin=1 -> sum=0xFFFD, cout=0, sign=1, overflow=0, zero=0.
- Handshake:
  - Assert start continuously with a new operand each cycle -> only operands sampled while busy==0 complete.
  - Completions are spaced 5 cycles apart.
  - sum holds its previous value until each done.
- Reset during RUN after 2 edges -> next cycle busy=0, done=0, all result outputs 0; no done pulse follows. A fresh start then completes normally.

Source files
------------

// File: rtl/chunked_adder_if.sv
// Request/result bundle for chunked_adder: operands and mode in, handshake and flags out.
interface chunked_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             sign;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow, zero, sign
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow, zero, sign
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: a WIDTH-bit operation is done CHUNK bits per clock, LSB slice first,
// with the carry held in a register so the longest carry chain is CHUNK+1 bits.
module chunked_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic            clk,
  input logic            rst,
  chunked_adder_if.slave bus
);
  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;

  logic [WIDTH-1:0] b_eff_c;
  logic [CHUNK:0]   slice_c;
  logic [WIDTH-1:0] res_shift_c;
  logic             ovf_c;

  // Operands shift right each cycle so the active slice is always the low CHUNK bits.
  assign b_eff_c     = bus.sub ? ~bus.b : bus.b;
  assign slice_c     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  assign res_shift_c = (res_q >> CHUNK) | (WIDTH'(slice_c[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign ovf_c       = (a_msb_q == b_msb_q) && (res_shift_c[WIDTH-1] != a_msb_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
    end
  end

  // Next-state and datapath updates; result flags move only on the last slice.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sign_d  = sign_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_eff_c;
          carry_d = bus.sub ^ bus.cin;
          idx_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = b_eff_c[WIDTH-1];
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift_c;
        carry_d = slice_c[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_shift_c;
          cout_d  = slice_c[CHUNK];
          ovf_d   = ovf_c;
          zero_d  = (res_shift_c == '0);
          sign_d  = res_shift_c[WIDTH-1] ^ ovf_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.sign     = sign_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder at WIDTH=16, CHUNK=4: expectations queued on accepted starts,
// checked on each done pulse, with reset, hold and back-to-back handshake checks.
module tb_chunked_adder;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             sign;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  chunked_adder_if #(.WIDTH(WIDTH)) bus ();

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               n_tests       = 0;
  int               n_fail        = 0;
  int               cyc           = 0;
  int               busy_run      = 0;
  int               last_done_cyc = -1;
  int               bb_dones      = 0;
  logic             bb_mode       = 1'b0;
  logic             rst_seen      = 1'b0;
  logic [WIDTH-1:0] last_sum      = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: true integer result for the signed flags, (WIDTH+1)-bit unsigned for sum/carry.
  function automatic exp_t model(input logic sb, input logic ci,
                                 input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    exp_t        e;
    logic [16:0] u;
    int          t;
    if (sb) begin
      t = int'($signed(aa)) - int'($signed(bb)) - int'(ci);
      u = 17'(aa) - 17'(bb) - 17'(ci);
    end else begin
      t = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
      u = 17'(aa) + 17'(bb) + 17'(ci);
    end
    e.sum  = u[15:0];
    e.cout = sb ? ~u[16] : u[16];
    e.ovf  = (t > 32767) || (t < -32768);
    e.sign = (t < 0);
    e.zero = (u[15:0] == 16'h0000);
    return e;
  endfunction

  always @(posedge clk) begin
    rst_seen <= rst;
    cyc      <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      check_eq("rst_busy", 32'(bus.busy), 32'(0));
      check_eq("rst_done", 32'(bus.done), 32'(0));
      check_eq("rst_sum", 32'(bus.sum), 32'(0));
      check_eq("rst_cout", 32'(bus.cout), 32'(0));
      check_eq("rst_ovf", 32'(bus.overflow), 32'(0));
      check_eq("rst_zero", 32'(bus.zero), 32'(0));
      check_eq("rst_sign", 32'(bus.sign), 32'(0));
      exp_q.delete();
      last_sum = '0;
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        check_eq("done_busy", 32'(bus.busy), 32'(0));
        check_eq("busy_cycles", 32'(busy_run), 32'(N));
        busy_run = 0;
        check_eq("done_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("sum", 32'(bus.sum), 32'(mon_e.sum));
          check_eq("cout", 32'(bus.cout), 32'(mon_e.cout));
          check_eq("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
          check_eq("zero", 32'(bus.zero), 32'(mon_e.zero));
          check_eq("sign", 32'(bus.sign), 32'(mon_e.sign));
          last_sum = mon_e.sum;
        end
        if (bb_mode) begin
          if (last_done_cyc >= 0) check_eq("done_spacing", 32'(cyc - last_done_cyc), 32'(N + 1));
          last_done_cyc = cyc;
          bb_dones++;
        end
      end else begin
        check_eq("sum_hold", 32'(bus.sum), 32'(last_sum));
      end
    end
  end

  // One clock of stimulus; a start seen with busy low is accepted at the coming edge.
  task automatic drive(input logic s, input logic sb, input logic ci,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    bus.start = s;
    bus.sub   = sb;
    bus.cin   = ci;
    bus.a     = aa;
    bus.b     = bb;
    if (s && !bus.busy && !rst) exp_q.push_back(model(sb, ci, aa, bb));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      drive(1'b0, 1'b0, 1'b0, 16'(k * 7919), 16'(k * 104729));
      k++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic run_op(input logic sb, input logic ci,
                        input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    drive(1'b1, sb, ci, aa, bb);
    wait_drain(4 * N + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    run_op(1'b0, 1'b0, 16'h7FFF, 16'h0001);
    run_op(1'b0, 1'b0, 16'hFFFF, 16'h0001);
    run_op(1'b1, 1'b0, 16'h0005, 16'h0005);
    run_op(1'b1, 1'b0, 16'h8000, 16'h0001);
    run_op(1'b1, 1'b1, 16'h0003, 16'h0005);
    run_op(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    run_op(1'b1, 1'b0, 16'h0000, 16'h8000);
    run_op(1'b0, 1'b1, 16'h0FFF, 16'h0000);
    for (int i = 0; i < 10; i++)
      run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

    // Continuous start: only operands presented while busy is low complete.
    bb_mode       = 1'b1;
    last_done_cyc = -1;
    bb_dones      = 0;
    for (int i = 0; i < 13; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    bus.start = 1'b0;
    wait_drain(4 * N + 4);
    bb_mode = 1'b0;
    check_eq("bb_completions", 32'(bb_dones), 32'(3));

    // Reset two slices into an operation; nothing from it may complete.
    run_op(1'b0, 1'b0, 16'h1234, 16'h4321);
    drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    repeat (2 * N + 2) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    run_op(1'b0, 1'b0, 16'hABCD, 16'h1111);
    run_op(1'b1, 1'b1, 16'h0001, 16'h0000);

    check_eq("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
